// File: rtl/pal_composite_encoder.sv
// PAL composite video encoder.
//
// A free-running 32-bit phase accumulator drives a sine/cosine lookup for the
// colour subcarrier. Three register stages follow:
//   stage 1 : capture inputs plus the subcarrier sin/cos for this sample
//   stage 2 : QAM-modulate U/V into a chroma value (PAL V-switch, burst)
//   stage 3 : pick sync/burst/blank/active level, clamp to a 10-bit code
// Input-to-composite latency is 3 clocks, one sample per clock, no stalls.
//
// Ports
//   palClock        : pixel clock, all logic on the rising edge
//   reset_n         : synchronous active-low reset
//   y, u, v         : signed 9-bit luma / colour difference (y 255 = white)
//   blank/sync/burst: line timing qualifiers, priority sync > burst > blank
//   linePhase       : PAL switch, 1 = V axis inverted on this line
//   composite       : 10-bit composite sample code (292 = blanking level)
//   subcarrierPhase : phase[31:24] used for the sample now in stage 1
module pal_composite_encoder #(
  parameter logic [31:0] PHASE_INC = 32'd1290999825
) (
  input  logic              palClock,
  input  logic              reset_n,
  input  logic signed [8:0] y,
  input  logic signed [8:0] u,
  input  logic signed [8:0] v,
  input  logic              blank,
  input  logic              sync,
  input  logic              burst,
  input  logic              linePhase,
  output logic [9:0]        composite,
  output logic [7:0]        subcarrierPhase
);

  localparam logic [9:0] BLANK_LEVEL = 10'd292;

  // First quarter of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic signed [7:0] quarter_sin(input logic [6:0] k);
    logic signed [7:0] r;
    case (k)
      7'd0:  r = 8'sd0;   7'd1:  r = 8'sd3;   7'd2:  r = 8'sd6;   7'd3:  r = 8'sd9;
      7'd4:  r = 8'sd12;  7'd5:  r = 8'sd16;  7'd6:  r = 8'sd19;  7'd7:  r = 8'sd22;
      7'd8:  r = 8'sd25;  7'd9:  r = 8'sd28;  7'd10: r = 8'sd31;  7'd11: r = 8'sd34;
      7'd12: r = 8'sd37;  7'd13: r = 8'sd40;  7'd14: r = 8'sd43;  7'd15: r = 8'sd46;
      7'd16: r = 8'sd49;  7'd17: r = 8'sd51;  7'd18: r = 8'sd54;  7'd19: r = 8'sd57;
      7'd20: r = 8'sd60;  7'd21: r = 8'sd63;  7'd22: r = 8'sd65;  7'd23: r = 8'sd68;
      7'd24: r = 8'sd71;  7'd25: r = 8'sd73;  7'd26: r = 8'sd76;  7'd27: r = 8'sd78;
      7'd28: r = 8'sd81;  7'd29: r = 8'sd83;  7'd30: r = 8'sd85;  7'd31: r = 8'sd88;
      7'd32: r = 8'sd90;  7'd33: r = 8'sd92;  7'd34: r = 8'sd94;  7'd35: r = 8'sd96;
      7'd36: r = 8'sd98;  7'd37: r = 8'sd100; 7'd38: r = 8'sd102; 7'd39: r = 8'sd104;
      7'd40: r = 8'sd106; 7'd41: r = 8'sd107; 7'd42: r = 8'sd109; 7'd43: r = 8'sd111;
      7'd44: r = 8'sd112; 7'd45: r = 8'sd113; 7'd46: r = 8'sd115; 7'd47: r = 8'sd116;
      7'd48: r = 8'sd117; 7'd49: r = 8'sd118; 7'd50: r = 8'sd120; 7'd51: r = 8'sd121;
      7'd52: r = 8'sd122; 7'd53: r = 8'sd122; 7'd54: r = 8'sd123; 7'd55: r = 8'sd124;
      7'd56: r = 8'sd125; 7'd57: r = 8'sd125; 7'd58: r = 8'sd126; 7'd59: r = 8'sd126;
      7'd60: r = 8'sd126; 7'd61: r = 8'sd127; 7'd62: r = 8'sd127; 7'd63: r = 8'sd127;
      default: r = 8'sd127;
    endcase
    return r;
  endfunction

  // Full 256-entry sine from quarter-wave symmetry: the second quarter
  // mirrors the first, the second half is the negated first half.
  function automatic logic signed [7:0] sin_lut(input logic [7:0] p);
    logic [6:0]        q;
    logic [6:0]        idx;
    logic signed [7:0] mag;
    q   = p[6:0];
    idx = (q > 7'd64) ? (7'd0 - q) : q;  // 128 - q modulo 128
    mag = quarter_sin(idx);
    return p[7] ? -mag : mag;
  endfunction

  // Phase accumulator
  logic [31:0] phase_q, phase_d;

  // Stage 1
  logic signed [8:0] y_s1_q, y_s1_d, u_s1_q, u_s1_d, v_s1_q, v_s1_d;
  logic              blank_s1_q, blank_s1_d, sync_s1_q, sync_s1_d;
  logic              burst_s1_q, burst_s1_d, lp_s1_q, lp_s1_d;
  logic signed [7:0] sin_s1_q, sin_s1_d, cos_s1_q, cos_s1_d;
  logic [7:0]        ph_s1_q, ph_s1_d;

  // Stage 2
  logic signed [8:0]  y_s2_q, y_s2_d;
  logic signed [10:0] chroma_s2_q, chroma_s2_d;
  logic               blank_s2_q, blank_s2_d, sync_s2_q, sync_s2_d;
  logic               burst_s2_q, burst_s2_d;

  // Stage 3
  logic [9:0] composite_q, composite_d;

  logic signed [9:0]  u_eff, v_eff, v_sw;
  logic signed [19:0] prod;
  logic signed [12:0] level;

  always_comb begin
    phase_d    = phase_q + PHASE_INC;

    y_s1_d     = y;
    u_s1_d     = u;
    v_s1_d     = v;
    blank_s1_d = blank;
    sync_s1_d  = sync;
    burst_s1_d = burst;
    lp_s1_d    = linePhase;
    ph_s1_d    = phase_q[31:24];
    sin_s1_d   = sin_lut(phase_q[31:24]);
    cos_s1_d   = sin_lut(phase_q[31:24] + 8'd64);

    // Burst is a fixed U=-48/V=+48 vector; the V switch then swings it
    // between 135 and 225 degrees on alternate lines.
    u_eff = burst_s1_q ? -10'sd48 : 10'(u_s1_q);
    v_eff = burst_s1_q ?  10'sd48 : 10'(v_s1_q);
    v_sw  = lp_s1_q ? -v_eff : v_eff;
    prod  = 20'(u_eff) * 20'(sin_s1_q) + 20'(v_sw) * 20'(cos_s1_q);
    chroma_s2_d = 11'(prod >>> 6);   // floor division by 64
    y_s2_d      = y_s1_q;
    blank_s2_d  = blank_s1_q;
    sync_s2_d   = sync_s1_q;
    burst_s2_d  = burst_s1_q;

    if (sync_s2_q)       level = 13'sd0;
    else if (burst_s2_q) level = 13'sd292 + 13'(chroma_s2_q);
    else if (blank_s2_q) level = 13'sd292;
    else                 level = 13'sd292 + (13'(y_s2_q) <<< 1) + 13'(chroma_s2_q);

    if (level < 13'sd0)         composite_d = 10'd0;
    else if (level > 13'sd1023) composite_d = 10'd1023;
    else                        composite_d = level[9:0];
  end

  always_ff @(posedge palClock) begin
    if (!reset_n) begin
      phase_q     <= '0;
      y_s1_q      <= '0;
      u_s1_q      <= '0;
      v_s1_q      <= '0;
      blank_s1_q  <= 1'b1;
      sync_s1_q   <= 1'b0;
      burst_s1_q  <= 1'b0;
      lp_s1_q     <= 1'b0;
      sin_s1_q    <= '0;
      cos_s1_q    <= '0;
      ph_s1_q     <= '0;
      y_s2_q      <= '0;
      chroma_s2_q <= '0;
      blank_s2_q  <= 1'b1;
      sync_s2_q   <= 1'b0;
      burst_s2_q  <= 1'b0;
      composite_q <= BLANK_LEVEL;
    end else begin
      phase_q     <= phase_d;
      y_s1_q      <= y_s1_d;
      u_s1_q      <= u_s1_d;
      v_s1_q      <= v_s1_d;
      blank_s1_q  <= blank_s1_d;
      sync_s1_q   <= sync_s1_d;
      burst_s1_q  <= burst_s1_d;
      lp_s1_q     <= lp_s1_d;
      sin_s1_q    <= sin_s1_d;
      cos_s1_q    <= cos_s1_d;
      ph_s1_q     <= ph_s1_d;
      y_s2_q      <= y_s2_d;
      chroma_s2_q <= chroma_s2_d;
      blank_s2_q  <= blank_s2_d;
      sync_s2_q   <= sync_s2_d;
      burst_s2_q  <= burst_s2_d;
      composite_q <= composite_d;
    end
  end

  assign composite       = composite_q;
  assign subcarrierPhase = ph_s1_q;

endmodule

// File: tb/tb_pal_composite_encoder.sv
// Bench for pal_composite_encoder: one instance with PHASE_INC = 0 (static
// subcarrier, sin = 0, cos = 127) for literal level checks, one with the
// default increment. Both run against a per-edge reference model.
module tb_pal_composite_encoder;

  localparam logic [31:0] INC_DEF = 32'd1290999825;
  localparam int RAND_CYCLES = 20000;

  logic              palClock = 1'b0;
  logic              reset_n;
  logic signed [8:0] y, u, v;
  logic              blank, sync, burst, linePhase;
  logic [9:0]        comp0, comp1;
  logic [7:0]        sph0, sph1;

  pal_composite_encoder #(.PHASE_INC(32'd0)) dut0 (
    .palClock(palClock), .reset_n(reset_n), .y(y), .u(u), .v(v),
    .blank(blank), .sync(sync), .burst(burst), .linePhase(linePhase),
    .composite(comp0), .subcarrierPhase(sph0));

  pal_composite_encoder dut1 (
    .palClock(palClock), .reset_n(reset_n), .y(y), .u(u), .v(v),
    .blank(blank), .sync(sync), .burst(burst), .linePhase(linePhase),
    .composite(comp1), .subcarrierPhase(sph1));

  always #5 palClock = ~palClock;

  int total = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int sin_tab[256];

  function automatic int model_level(input int yy, input int uu, input int vv,
                                     input bit bl, input bit sy, input bit bu,
                                     input bit lp, input int ph);
    int s, c, ue, ve, chroma, r;
    s  = sin_tab[ph];
    c  = sin_tab[(ph + 64) % 256];
    ue = bu ? -48 : uu;
    ve = bu ?  48 : vv;
    if (lp) ve = -ve;
    chroma = (ue * s + ve * c) >>> 6;
    if (sy)      r = 0;
    else if (bu) r = 292 + chroma;
    else if (bl) r = 292;
    else         r = 292 + 2 * yy + chroma;
    if (r < 0)    r = 0;
    if (r > 1023) r = 1023;
    return r;
  endfunction

  logic [31:0] acc[2];
  int  exp_comp[2], exp_ph[2];
  int  val_h[2][3];     // model value for the last 3 edges, [0] newest
  bit  rst_h[3];
  bit  seen_rst = 0;

  initial begin
    for (int k = 0; k < 256; k++)
      sin_tab[k] = int'(127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0));
    for (int k = 0; k < 3; k++) rst_h[k] = 1'b1;
    forever begin
      @(posedge palClock);
      for (int k = 2; k > 0; k--) begin
        rst_h[k] = rst_h[k-1];
        for (int d = 0; d < 2; d++) val_h[d][k] = val_h[d][k-1];
      end
      rst_h[0] = !reset_n;
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          acc[d] = 0;
          exp_ph[d] = 0;
          val_h[d][0] = 292;
        end else begin
          exp_ph[d] = int'(acc[d][31:24]);
          val_h[d][0] = model_level(y, u, v, blank, sync, burst, linePhase, exp_ph[d]);
          acc[d] = acc[d] + ((d == 0) ? 32'd0 : INC_DEF);
        end
        // any reset within the 3-deep pipeline window yields blanking
        exp_comp[d] = (rst_h[0] || rst_h[1] || rst_h[2]) ? 292 : val_h[d][2];
      end
      if (!reset_n) seen_rst = 1;
    end
  end

  initial begin
    forever begin
      @(negedge palClock);
      if (seen_rst) begin
        chk("model_comp0", comp0, exp_comp[0]);
        chk("model_comp1", comp1, exp_comp[1]);
        chk("model_phase0", sph0, exp_ph[0]);
        chk("model_phase1", sph1, exp_ph[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge palClock);
    #2;
  endtask

  task automatic set_in(input int yy, input int uu, input int vv, input bit bl,
                        input bit sy, input bit bu, input bit lp);
    y = 9'(yy); u = 9'(uu); v = 9'(vv);
    blank = bl; sync = sy; burst = bu; linePhase = lp;
  endtask

  task automatic hold_check(input string name, input int exp);
    repeat (3) step();
    chk(name, comp0, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 1, 1, 0, 0);

    // reset held with sync asserted
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_comp", comp0, 292);
      chk("rst_phase0", sph0, 0);
      chk("rst_phase1", sph1, 0);
    end
    reset_n = 1'b1;
    step();
    chk("rel_c1", comp0, 292);
    chk("rel_ph1", sph1, 0);
    step();
    chk("rel_c2", comp0, 292);
    chk("rel_ph2", sph1, 76);
    step();
    chk("rel_c3_sync", comp0, 0);
    chk("rel_c3_sync1", comp1, 0);
    chk("rel_ph3", sph1, 153);

    // levels and chroma with a static subcarrier
    set_in(0, 0, 0, 1, 0, 0, 0);      hold_check("blank", 292);
    set_in(235, 0, 0, 0, 0, 0, 0);    hold_check("white235", 762);
    set_in(-10, 0, 0, 0, 0, 0, 0);    hold_check("neg_y", 272);
    set_in(255, 0, 127, 0, 0, 0, 0);  hold_check("chroma_clamp", 1023);
    set_in(255, 0, 127, 0, 0, 0, 1);  hold_check("chroma_lp1", 549);
    set_in(0, 0, 0, 1, 0, 1, 0);      hold_check("burst_lp0", 387);
    set_in(0, 0, 0, 1, 0, 1, 1);      hold_check("burst_lp1", 196);
    set_in(0, 0, 0, 1, 1, 1, 0);      hold_check("sync_over_burst", 0);
    set_in(100, 50, 50, 0, 0, 1, 0);  hold_check("burst_noblank", 387);

    // mid-line reset flushes in-flight samples
    set_in(235, 0, 0, 0, 0, 0, 0);    hold_check("pre_midrst", 762);
    reset_n = 1'b0;
    step();
    chk("midrst_c0", comp0, 292);
    reset_n = 1'b1;
    step();
    chk("midrst_c1", comp0, 292);
    step();
    chk("midrst_c2", comp0, 292);
    step();
    chk("midrst_c3", comp0, 762);

    // randomized traffic with occasional single-clock resets
    for (int i = 0; i < RAND_CYCLES; i++) begin
      reset_n   = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      y         = 9'($urandom_range(0, 511));
      u         = 9'($urandom_range(0, 511));
      v         = 9'($urandom_range(0, 511));
      blank     = ($urandom_range(0, 3) == 0);
      sync      = ($urandom_range(0, 7) == 0);
      burst     = ($urandom_range(0, 5) == 0);
      linePhase = $urandom_range(0, 1) != 0;
      step();
    end
    reset_n = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
